or1k_branch_resolver: RTL and testbench
=======================================

# or1k_branch_resolver

Execute-side companion to the decode-stage static branch predictor. Captures each conditional branch (l.bf / l.bnf) with its predicted flag when decode advances, holds it until the architectural flag is resolved, then emits a one-cycle resolve/mispredict pulse with the corrected fetch target. Sits between decode and the fetch redirect logic; one branch in flight at a time.

## Interface
- OPTION_OPERAND_WIDTH, 32: PC/target width.
- OPTION_DELAY_SLOT, 1: 1 = fall-through is pc+8 (delay slot); 0 = pc+4.
- STAT_WIDTH, 32: statistics counter width (only with OR1K_BRANCH_STATS_EN).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- decode_valid_i  in  1  decode advances this cycle.
- decode_op_bf_i  in  1  instruction is l.bf.
- decode_op_bnf_i  in  1  instruction is l.bnf.
- decode_predicted_flag_i  in  1  predictor output for this instruction.
- decode_pc_i  in  OPTION_OPERAND_WIDTH  branch PC.
- decode_immjbr_i  in  26  word offset, two's complement.
- ctrl_flag_i  in  1  architectural SR[F].
- ctrl_flag_valid_i  in  1  ctrl_flag_i final (no flag writer in flight).
- pipeline_flush_i  in  1  discard pending branch.
- stall_o  out  1  hold decode: new branch while one pending.
- branch_pending_o  out  1  state is PENDING.
- resolved_o  out  1  one-cycle pulse, branch resolved.
- mispredict_o  out  1  one-cycle pulse, qualifies resolved_o.
- mispredict_target_o  out  OPTION_OPERAND_WIDTH  correct next-fetch PC, valid with mispredict_o.
- branch_count_o  out  STAT_WIDTH  resolved branches (macro only).
- mispredict_count_o  out  STAT_WIDTH  mispredicts (macro only).

## Operation
- States: IDLE, PENDING. Reset: IDLE; all outputs 0, target 0, counters 0.
- IDLE: decode_valid_i & (bf|bnf) -> capture op, predicted flag, pc, imm; -> PENDING. bf and bnf both high is illegal; bf takes priority.
- PENDING: if ctrl_flag_valid_i: taken = bf ? ctrl_flag_i : !ctrl_flag_i; mispredict = taken != predicted; -> IDLE; resolved_o=1, mispredict_o=mispredict next cycle. Else stay.
- Target: taken ? pc + (sign_ext(imm) << 2) : pc + (OPTION_DELAY_SLOT ? 8 : 4). Modulo 2^OPTION_OPERAND_WIDTH, wrap silently.
- stall_o = PENDING & decode_op_(bf|bnf) (combinational); stalled branch not captured, including the cycle PENDING resolves.
- Non-branch decode traffic never stalled, never captured.
- pipeline_flush_i: -> IDLE, no pulse, counters unchanged. Priority rst > flush > resolve > capture.
- mispredict_target_o holds last value when mispredict_o low.

## Timing
- Capture edge E0; earliest flag sample cycle after E0; resolution edge E1 >= E0+1; pulses high exactly the cycle after E1.
- Minimum branch-to-branch spacing: 2 cycles (new branch captured in cycle after E1, while pulses are high).
- stall_o has zero latency; all other outputs registered.
- Flush and ctrl_flag_valid_i same cycle: no pulse.

## Configuration
- OR1K_BRANCH_STATS_EN defined: branch_count_o +1 per resolved_o, mispredict_count_o +1 per mispredict_o, both saturate at all-ones, reset to 0.
- Undefined: counters absent, both outputs tied to 0, no stats logic.

## Structure
- Shared package: state encoding (IDLE/PENDING), fall-through offsets (4, 8), immjbr width 26.
- Sub-module or1k_sat_counter (parameterised width, inc, saturating), instantiated twice under OR1K_BRANCH_STATS_EN.

## Test plan
- bf, pc=0x1000, imm=-4, pred=1, flag valid 1 cycle later flag=1 -> resolved_o pulse, mispredict_o=0.
- bnf, pc=0x2000, imm=+16, pred=1, flag=1 (not taken) -> mispredict_o=1, target=0x2008 (delay slot) / 0x2004 (OPTION_DELAY_SLOT=0).
- bf, pc=0x3000, imm=+0x10, pred=0, flag_valid low 5 cycles then flag=1 -> branch_pending_o 6 cycles, mispredict target 0x3040.
- Second bf in decode while pending -> stall_o=1 until resolution, captured cycle after E1, not lost.
- Pending + pipeline_flush_i with flag valid same cycle -> IDLE, no pulse, counts unchanged; rst mid-PENDING -> all outputs 0.
- Macro on, STAT_WIDTH=2, 5 mispredicts -> mispredict_count_o=3, branch_count_o=3 saturated.

Source files
------------

// File: rtl/or1k_branch_resolver_pkg.sv
// Shared definitions for the OR1K branch resolver: FSM encoding, fall-through
// offsets and the l.bf/l.bnf immediate width.
package or1k_branch_resolver_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam int IMMJBR_WIDTH   = 26;
  localparam int FALLTHRU_NO_DS = 4;
  localparam int FALLTHRU_DS    = 8;

  // Not-taken successor distance; the delay slot pushes it one word further.
  function automatic int fallthrough_offset(input int delay_slot);
    if (delay_slot != 0) begin
      return FALLTHRU_DS;
    end else begin
      return FALLTHRU_NO_DS;
    end
  endfunction

endpackage

// File: rtl/or1k_sat_counter.sv
// Saturating up-counter used for branch statistics; sticks at all-ones.
module or1k_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register: increment until every bit is set, then hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (inc && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/or1k_branch_resolver.sv
// Execute-side resolver for statically predicted l.bf/l.bnf branches.
// Optional statistics counters are built when OR1K_BRANCH_STATS_EN is defined.
module or1k_branch_resolver
  import or1k_branch_resolver_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_DELAY_SLOT    = 1,
  parameter int STAT_WIDTH           = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            decode_valid_i,
  input  logic                            decode_op_bf_i,
  input  logic                            decode_op_bnf_i,
  input  logic                            decode_predicted_flag_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i,
  input  logic [IMMJBR_WIDTH-1:0]         decode_immjbr_i,
  input  logic                            ctrl_flag_i,
  input  logic                            ctrl_flag_valid_i,
  input  logic                            pipeline_flush_i,
  output logic                            stall_o,
  output logic                            branch_pending_o,
  output logic                            resolved_o,
  output logic                            mispredict_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] mispredict_target_o,
  output logic [STAT_WIDTH-1:0]           branch_count_o,
  output logic [STAT_WIDTH-1:0]           mispredict_count_o
);

  localparam int W = OPTION_OPERAND_WIDTH;
  localparam logic [W-1:0] FALLTHRU = W'(fallthrough_offset(OPTION_DELAY_SLOT));

  state_t                  state_r;
  state_t                  state_next_s;

  logic                    op_bf_r;
  logic                    pred_r;
  logic [W-1:0]            pc_r;
  logic [IMMJBR_WIDTH-1:0] imm_r;

  logic                    resolved_r;
  logic                    mispredict_r;
  logic [W-1:0]            target_r;

  logic                    is_branch_s;
  logic                    stall_s;
  logic                    capture_s;
  logic                    resolve_s;
  logic                    taken_s;
  logic                    mispredict_s;
  logic [W-1:0]            imm_ext_s;
  logic [W-1:0]            target_s;

  assign is_branch_s = decode_op_bf_i | decode_op_bnf_i;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: flush beats resolution, resolution beats capture.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pipeline_flush_i) begin
          state_next_s = ST_IDLE;
        end else if (decode_valid_i && is_branch_s) begin
          state_next_s = ST_PENDING;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (pipeline_flush_i || ctrl_flag_valid_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_PENDING;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: stall is raw decode opcode while pending, even in the resolve cycle.
  always_comb begin
    stall_s   = 1'b0;
    capture_s = 1'b0;
    resolve_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stall_s   = 1'b0;
        capture_s = ~pipeline_flush_i & decode_valid_i & is_branch_s;
        resolve_s = 1'b0;
      end
      ST_PENDING: begin
        stall_s   = is_branch_s;
        capture_s = 1'b0;
        resolve_s = ~pipeline_flush_i & ctrl_flag_valid_i;
      end
      default: begin
        stall_s   = 1'b0;
        capture_s = 1'b0;
        resolve_s = 1'b0;
      end
    endcase
  end

  assign stall_o = stall_s;

  // Resolution datapath: direction from the architectural flag, target wraps modulo 2^W.
  always_comb begin
    taken_s      = op_bf_r ? ctrl_flag_i : ~ctrl_flag_i;
    mispredict_s = taken_s ^ pred_r;
    imm_ext_s    = {{(W - IMMJBR_WIDTH){imm_r[IMMJBR_WIDTH-1]}}, imm_r};
    if (taken_s) begin
      target_s = pc_r + {imm_ext_s[W-3:0], 2'b00};
    end else begin
      target_s = pc_r + FALLTHRU;
    end
  end

  // Branch capture; bf wins if decode ever presents both opcodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_bf_r <= 1'b0;
      pred_r  <= 1'b0;
      pc_r    <= '0;
      imm_r   <= '0;
    end else if (capture_s) begin
      op_bf_r <= decode_op_bf_i;
      pred_r  <= decode_predicted_flag_i;
      pc_r    <= decode_pc_i;
      imm_r   <= decode_immjbr_i;
    end else begin
      op_bf_r <= op_bf_r;
      pred_r  <= pred_r;
      pc_r    <= pc_r;
      imm_r   <= imm_r;
    end
  end

  // Registered pulses; the target only moves on a mispredict.
  always_ff @(posedge clk) begin
    if (rst) begin
      resolved_r   <= 1'b0;
      mispredict_r <= 1'b0;
      target_r     <= '0;
    end else begin
      resolved_r   <= resolve_s;
      mispredict_r <= resolve_s & mispredict_s;
      if (resolve_s && mispredict_s) begin
        target_r <= target_s;
      end else begin
        target_r <= target_r;
      end
    end
  end

  assign branch_pending_o    = (state_r == ST_PENDING);
  assign resolved_o          = resolved_r;
  assign mispredict_o        = mispredict_r;
  assign mispredict_target_o = target_r;

`ifdef OR1K_BRANCH_STATS_EN
  logic [STAT_WIDTH-1:0] branch_count_s;
  logic [STAT_WIDTH-1:0] mispredict_count_s;

  or1k_sat_counter #(.WIDTH(STAT_WIDTH)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (resolved_r),
    .count (branch_count_s)
  );

  or1k_sat_counter #(.WIDTH(STAT_WIDTH)) u_mispredict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mispredict_r),
    .count (mispredict_count_s)
  );

  assign branch_count_o     = branch_count_s;
  assign mispredict_count_o = mispredict_count_s;
`else
  assign branch_count_o     = '0;
  assign mispredict_count_o = '0;
`endif

endmodule

// File: tb/tb_or1k_branch_resolver.sv
// Self-checking bench for or1k_branch_resolver: directed table, corner sequences
// and randomized traffic against a cycle-level behavioural model.
module tb_or1k_branch_resolver;

  localparam int W  = 32;
  localparam int SW = 2;
`ifdef OR1K_BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int CNT_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst, dv, bf, bnf, pred, flag, fv, flush;
  logic [W-1:0]  pc;
  logic [25:0]   imm;
  logic          stall_o, branch_pending_o, resolved_o, mispredict_o;
  logic [W-1:0]  mispredict_target_o;
  logic [SW-1:0] branch_count_o, mispredict_count_o;

  always #5 clk = ~clk;

  or1k_branch_resolver #(
    .OPTION_OPERAND_WIDTH (W),
    .OPTION_DELAY_SLOT    (1),
    .STAT_WIDTH           (SW)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .decode_valid_i          (dv),
    .decode_op_bf_i          (bf),
    .decode_op_bnf_i         (bnf),
    .decode_predicted_flag_i (pred),
    .decode_pc_i             (pc),
    .decode_immjbr_i         (imm),
    .ctrl_flag_i             (flag),
    .ctrl_flag_valid_i       (fv),
    .pipeline_flush_i        (flush),
    .stall_o                 (stall_o),
    .branch_pending_o        (branch_pending_o),
    .resolved_o              (resolved_o),
    .mispredict_o            (mispredict_o),
    .mispredict_target_o     (mispredict_target_o),
    .branch_count_o          (branch_count_o),
    .mispredict_count_o      (mispredict_count_o)
  );

  typedef struct {
    logic        rst, dv, bf, bnf, pred;
    logic [31:0] pc;
    logic [25:0] imm;
    logic        flag, fv, flush;
    logic        x_stall, x_pend, x_res, x_mis;
    logic [31:0] x_tgt;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state: one pending branch plus the expected outputs.
  bit          m_pend, m_bf, m_pred;
  logic [W-1:0] m_pc;
  logic [25:0] m_imm;
  bit          e_res, e_mis;
  logic [W-1:0] e_tgt;
  int          e_bc, e_mc;

  function automatic vec_t mk(input logic r, input logic d, input logic b, input logic n,
                              input logic p, input logic [31:0] a, input logic [25:0] i,
                              input logic f, input logic v, input logic fl,
                              input logic xs, input logic xp, input logic xr,
                              input logic xm, input logic [31:0] xt);
    vec_t t;
    t.rst = r; t.dv = d; t.bf = b; t.bnf = n; t.pred = p; t.pc = a; t.imm = i;
    t.flag = f; t.fv = v; t.flush = fl;
    t.x_stall = xs; t.x_pend = xp; t.x_res = xr; t.x_mis = xm; t.x_tgt = xt;
    return t;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle.
  task automatic model_edge();
    int off;
    bit taken;
    if (rst) begin
      m_pend = 1'b0; e_res = 1'b0; e_mis = 1'b0; e_tgt = '0; e_bc = 0; e_mc = 0;
    end else begin
      if (STATS && e_res && e_bc < CNT_MAX) e_bc++;
      if (STATS && e_mis && e_mc < CNT_MAX) e_mc++;
      e_res = 1'b0;
      e_mis = 1'b0;
      if (flush) begin
        m_pend = 1'b0;
      end else if (m_pend && fv) begin
        taken = m_bf ? flag : !flag;
        e_res = 1'b1;
        e_mis = (taken != m_pred);
        off   = $signed(m_imm);
        if (e_mis) e_tgt = taken ? m_pc + W'(off * 4) : m_pc + 32'd8;
        m_pend = 1'b0;
      end else if (!m_pend && dv && (bf || bnf)) begin
        m_pend = 1'b1; m_bf = bf; m_pred = pred; m_pc = pc; m_imm = imm;
      end
    end
  endtask

  task automatic step(input vec_t v, input bit use_tbl);
    rst = v.rst; dv = v.dv; bf = v.bf; bnf = v.bnf; pred = v.pred; pc = v.pc;
    imm = v.imm; flag = v.flag; fv = v.fv; flush = v.flush;
    #2;
    check("stall", stall_o, use_tbl ? v.x_stall : (m_pend && (v.bf || v.bnf)));
    @(posedge clk);
    model_edge();
    #1;
    check("pending", branch_pending_o, use_tbl ? v.x_pend : m_pend);
    check("resolved", resolved_o, use_tbl ? v.x_res : e_res);
    check("mispredict", mispredict_o, use_tbl ? v.x_mis : e_mis);
    check("target", mispredict_target_o, use_tbl ? v.x_tgt : e_tgt);
    check("branch_count", branch_count_o, e_bc);
    check("mispredict_count", mispredict_count_o, e_mc);
  endtask

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t br(input logic b, input logic p, input logic [31:0] a, input logic [25:0] i);
    return mk(0, 1, b, !b, p, a, i, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t res(input logic f);
    return mk(0, 0, 0, 0, 0, 0, 0, f, 1, 0, 0, 0, 0, 0, 0);
  endfunction

  vec_t tbl[16];
  vec_t v;
  int   pend_cycles;
  int   r;

  initial begin
    // rst dv bf bnf pred pc imm flag fv flush | stall pend res mis target
    tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,        26'd0,         0, 0, 0, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 1, 1, 0, 1, 32'h1000,     26'h3FFFFFC,   0, 0, 0, 0, 1, 0, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 32'h0,        26'd0,         1, 1, 0, 0, 0, 1, 0, 32'h0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 32'h0,        26'd0,         0, 0, 0, 0, 0, 0, 0, 32'h0);
    tbl[4]  = mk(0, 1, 0, 1, 1, 32'h2000,     26'd16,        0, 0, 0, 0, 1, 0, 0, 32'h0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 32'h0,        26'd0,         1, 1, 0, 0, 0, 1, 1, 32'h2008);
    tbl[6]  = mk(0, 0, 0, 0, 0, 32'h0,        26'd0,         0, 0, 0, 0, 0, 0, 0, 32'h2008);
    tbl[7]  = mk(0, 1, 0, 0, 1, 32'h7000,     26'd5,         0, 0, 0, 0, 0, 0, 0, 32'h2008);
    tbl[8]  = mk(0, 1, 1, 0, 1, 32'hFFFFFFF8, 26'd0,         0, 0, 0, 0, 1, 0, 0, 32'h2008);
    tbl[9]  = mk(0, 1, 1, 0, 0, 32'h5000,     26'd1,         0, 1, 0, 1, 0, 1, 1, 32'h0);
    tbl[10] = mk(0, 1, 1, 0, 0, 32'h5000,     26'd1,         0, 0, 0, 0, 1, 0, 0, 32'h0);
    tbl[11] = mk(0, 0, 0, 0, 0, 32'h0,        26'd0,         0, 1, 0, 0, 0, 1, 0, 32'h0);
    tbl[12] = mk(0, 1, 1, 0, 0, 32'h6000,     26'd4,         0, 0, 0, 0, 1, 0, 0, 32'h0);
    tbl[13] = mk(0, 0, 0, 0, 0, 32'h0,        26'd0,         1, 1, 1, 0, 0, 0, 0, 32'h0);
    tbl[14] = mk(0, 1, 1, 0, 1, 32'h8000,     26'd2,         0, 0, 1, 0, 0, 0, 0, 32'h0);
    tbl[15] = mk(0, 0, 0, 0, 0, 32'h0,        26'd0,         0, 0, 0, 0, 0, 0, 0, 32'h0);

    rst = 1; dv = 0; bf = 0; bnf = 0; pred = 0; pc = '0; imm = '0; flag = 0; fv = 0; flush = 0;
    repeat (2) @(posedge clk);
    model_edge();
    #1;

    for (int i = 0; i < 16; i++) step(tbl[i], 1'b1);

    // Long wait for the flag: pending for six sampled cycles, taken mispredict.
    pend_cycles = 0;
    step(br(1, 0, 32'h3000, 26'h10), 1'b0);
    if (branch_pending_o) pend_cycles++;
    for (int i = 0; i < 5; i++) begin
      step(idle(), 1'b0);
      if (branch_pending_o) pend_cycles++;
    end
    step(res(1), 1'b0);
    check("wait_pend_cycles", W'(pend_cycles), 32'd6);
    check("wait_mispredict", mispredict_o, 1'b1);
    check("wait_target", mispredict_target_o, 32'h3040);

    // Second branch held in decode while one is pending, captured right after E1.
    step(br(1, 1, 32'h9000, 26'd3), 1'b0);
    v = br(1, 0, 32'hA000, 26'd8);
    for (int i = 0; i < 3; i++) step(v, 1'b0);
    v.fv = 1; v.flag = 1;
    step(v, 1'b0);
    check("stalled_resolve_pulse", resolved_o, 1'b1);
    v.fv = 0;
    step(v, 1'b0);
    check("stalled_captured", branch_pending_o, 1'b1);
    step(res(1), 1'b0);
    check("stalled_target", mispredict_target_o, 32'hA020);

    // Reset in the middle of a pending branch clears every output.
    step(br(1, 1, 32'h4000, 26'd7), 1'b0);
    v = res(1);
    v.rst = 1;
    step(v, 1'b0);
    check("rst_target", mispredict_target_o, 32'h0);
    check("rst_pending", branch_pending_o, 1'b0);

    // Five mispredicts drive both counters into saturation.
    for (int i = 0; i < 5; i++) begin
      step(br(1, 0, 32'h100 * i, 26'd1), 1'b0);
      step(res(1), 1'b0);
    end
    step(idle(), 1'b0);
    step(idle(), 1'b0);
    check("sat_mispredict_count", mispredict_count_o, STATS ? 32'd3 : 32'd0);
    check("sat_branch_count", branch_count_o, STATS ? 32'd3 : 32'd0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      v = mk($urandom_range(0, 99) < 2, 1'($urandom), r < 4 || r == 9, r >= 4, 1'($urandom),
             $urandom, 26'($urandom), 1'($urandom), $urandom_range(0, 99) < 40,
             $urandom_range(0, 99) < 5, 0, 0, 0, 0, 0);
      step(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
